// File: rtl/outmf_pingpong_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : outmf_pingpong_buf_if
// Description : Producer/consumer bundle for the ping-pong output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface outmf_pingpong_buf_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_commit;
    logic          wr_ready;
    logic          wr_bank;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_vld;
    logic          rd_frame_vld;
    logic          rd_release;
    logic          rd_bank;
    logic [1:0]    fill;
    logic [1:0]    err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
        input  wr_ready, wr_bank, rd_data, rd_data_vld, rd_frame_vld, rd_bank, fill, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
        output wr_ready, wr_bank, rd_data, rd_data_vld, rd_frame_vld, rd_bank, fill, err
    );
endinterface
`default_nettype wire

// File: rtl/outmf_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : outmf_pingpong_buf
// Description : Double-buffered output memory; producer fills one bank while
//               the consumer drains the other, swapping on commit/release.
// Revision    : 1.0 - initial release
// ============================================================================
module outmf_pingpong_buf #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int RD_LAT = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    outmf_pingpong_buf_if.slave  bus
);

    localparam int c_DEPTH = 2 ** (AW + 1);

    logic          r_wb;
    logic          r_rb;
    logic [1:0]    r_full;
    logic [1:0]    r_err;
    logic [DW-1:0] r_mem [c_DEPTH];
    logic [DW-1:0] r_q1;
    logic          r_vld1;

    logic          w_wr_ready;
    logic          w_frame_vld;
    logic          w_wr_ok;
    logic          w_commit_ok;
    logic          w_rd_ok;
    logic          w_rel_ok;
    logic          w_wr_viol;
    logic          w_rd_viol;
    logic [1:0]    w_full_nxt;

    assign w_wr_ready  = ~r_full[r_wb];
    assign w_frame_vld = r_full[r_rb];
    assign w_wr_ok     = bus.wr_en      & w_wr_ready;
    assign w_commit_ok = bus.wr_commit  & w_wr_ready;
    assign w_rd_ok     = bus.rd_en      & w_frame_vld;
    assign w_rel_ok    = bus.rd_release & w_frame_vld;
    assign w_wr_viol   = (bus.wr_en | bus.wr_commit) & ~w_wr_ready;
    assign w_rd_viol   = (bus.rd_en | bus.rd_release) & ~w_frame_vld;

    // Commit and release can only both be accepted on different banks,
    // so applying them in sequence never collides.
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit_ok) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_rel_ok) begin
            w_full_nxt[r_rb] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_full <= 2'b00;
            r_err  <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_commit_ok) begin
                r_wb <= ~r_wb;
            end
            if (w_rel_ok) begin
                r_rb <= ~r_rb;
            end
            if (w_wr_viol) begin
                r_err[0] <= 1'b1;
            end
            if (w_rd_viol) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[{r_wb, bus.wr_addr}] <= bus.wr_data;
        end
    end

    // Bank index is sampled with the address, so a same-cycle release
    // still reads the frame being freed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q1   <= '0;
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= w_rd_ok;
            if (w_rd_ok) begin
                r_q1 <= r_mem[{r_rb, bus.rd_addr}];
            end
        end
    end

    generate
        if (RD_LAT >= 2) begin : g_lat2
            logic [DW-1:0] r_q2;
            logic          r_vld2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q2   <= '0;
                    r_vld2 <= 1'b0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_q2 <= r_q1;
                    end
                end
            end

            assign bus.rd_data     = r_q2;
            assign bus.rd_data_vld = r_vld2;
        end else begin : g_lat1
            assign bus.rd_data     = r_q1;
            assign bus.rd_data_vld = r_vld1;
        end
    endgenerate

    assign bus.wr_ready     = w_wr_ready;
    assign bus.wr_bank      = r_wb;
    assign bus.rd_frame_vld = w_frame_vld;
    assign bus.rd_bank      = r_rb;
    assign bus.fill         = {1'b0, r_full[0]} + {1'b0, r_full[1]};
    assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_outmf_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_outmf_pingpong_buf
// Description : Directed bench for both read latencies of the ping-pong buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outmf_pingpong_buf;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    outmf_pingpong_buf_if #(.DW(32), .AW(5)) bus1 ();
    outmf_pingpong_buf_if #(.DW(32), .AW(5)) bus2 ();

    outmf_pingpong_buf #(.DW(32), .AW(5), .RD_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    outmf_pingpong_buf #(.DW(32), .AW(5), .RD_LAT(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic cmt);
        bus1.wr_en     = 1'b1;
        bus1.wr_addr   = a;
        bus1.wr_data   = d;
        bus1.wr_commit = cmt;
        tick();
        bus1.wr_en     = 1'b0;
        bus1.wr_commit = 1'b0;
    endtask

    task automatic commit1();
        bus1.wr_commit = 1'b1;
        tick();
        bus1.wr_commit = 1'b0;
    endtask

    task automatic release1();
        bus1.rd_release = 1'b1;
        tick();
        bus1.rd_release = 1'b0;
    endtask

    task automatic rd1(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus1.rd_en   = 1'b1;
        bus1.rd_addr = a;
        tick();
        bus1.rd_en   = 1'b0;
        chk({tag, "_vld"}, bus1.rd_data_vld, 1);
        chk({tag, "_data"}, bus1.rd_data, exp);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        vec_cnt = 0;
        err_cnt = 0;
        bus1.wr_en = 0; bus1.wr_addr = 0; bus1.wr_data = 0; bus1.wr_commit = 0;
        bus1.rd_en = 0; bus1.rd_addr = 0; bus1.rd_release = 0;
        bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_data = 0; bus2.wr_commit = 0;
        bus2.rd_en = 0; bus2.rd_addr = 0; bus2.rd_release = 0;
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_wr_ready", bus1.wr_ready, 1);
        chk("rst_wr_bank",  bus1.wr_bank, 0);
        chk("rst_rd_bank",  bus1.rd_bank, 0);
        chk("rst_frame",    bus1.rd_frame_vld, 0);
        chk("rst_fill",     bus1.fill, 0);
        chk("rst_err",      bus1.err, 0);
        chk("rst_rd_data",  bus1.rd_data, 0);
        chk("rst_rd_vld",   bus1.rd_data_vld, 0);

        // Frame A into bank 0, then drain it at latency 1
        for (int i = 0; i < 32; i++) wr1(5'(i), 32'hA000_0000 + 32'(i), 1'b0);
        chk("a_fill_pre", bus1.fill, 0);
        commit1();
        chk("a_fill",     bus1.fill, 1);
        chk("a_wr_bank",  bus1.wr_bank, 1);
        chk("a_frame",    bus1.rd_frame_vld, 1);
        chk("a_wr_ready", bus1.wr_ready, 1);
        for (int i = 0; i < 32; i++) begin
            bus1.rd_en   = 1'b1;
            bus1.rd_addr = 5'(i);
            tick();
            chk("a_rd_vld",  bus1.rd_data_vld, 1);
            chk("a_rd_data", bus1.rd_data, 32'hA000_0000 + 32'(i));
        end
        bus1.rd_en = 1'b0;
        tick();
        chk("a_idle_vld",  bus1.rd_data_vld, 0);
        chk("a_idle_hold", bus1.rd_data, 32'hA000_001F);

        // Frame B into bank 1: both banks full
        for (int i = 0; i < 32; i++) wr1(5'(i), 32'hB000_0000 + 32'(i), 1'b0);
        commit1();
        chk("b_fill",     bus1.fill, 2);
        chk("b_wr_ready", bus1.wr_ready, 0);
        chk("b_wr_bank",  bus1.wr_bank, 0);
        wr1(5'd3, 32'hDEAD_BEEF, 1'b0);
        chk("b_wr_err",   bus1.err, 2'b01);
        chk("b_fill2",    bus1.fill, 2);
        release1();
        chk("b_rd_bank",  bus1.rd_bank, 1);
        chk("b_wr_ready2", bus1.wr_ready, 1);
        chk("b_fill3",    bus1.fill, 1);
        rd1("b_rd0",  5'd0,  32'hB000_0000);
        rd1("b_rd3",  5'd3,  32'hB000_0003);
        rd1("b_rd31", 5'd31, 32'hB000_001F);

        // Simultaneous commit (bank 0) and release (bank 1)
        bus1.wr_commit  = 1'b1;
        bus1.rd_release = 1'b1;
        tick();
        bus1.wr_commit  = 1'b0;
        bus1.rd_release = 1'b0;
        chk("cr_fill",    bus1.fill, 1);
        chk("cr_wr_bank", bus1.wr_bank, 1);
        chk("cr_rd_bank", bus1.rd_bank, 0);
        chk("cr_err",     bus1.err, 2'b01);
        rd1("cr_rd3",  5'd3,  32'hA000_0003);
        rd1("cr_rd31", 5'd31, 32'hA000_001F);

        // Write+commit same cycle into bank 1, then read+release on addr 5
        wr1(5'd5, 32'h0000_0055, 1'b1);
        chk("wc_fill",    bus1.fill, 2);
        chk("wc_wr_bank", bus1.wr_bank, 0);
        release1();
        chk("wc_rd_bank", bus1.rd_bank, 1);
        bus1.rd_en      = 1'b1;
        bus1.rd_addr    = 5'd5;
        bus1.rd_release = 1'b1;
        tick();
        bus1.rd_en      = 1'b0;
        bus1.rd_release = 1'b0;
        chk("rr_data",    bus1.rd_data, 32'h55);
        chk("rr_vld",     bus1.rd_data_vld, 1);
        chk("rr_frame",   bus1.rd_frame_vld, 0);
        chk("rr_fill",    bus1.fill, 0);
        chk("rr_rd_bank", bus1.rd_bank, 0);
        bus1.rd_en = 1'b1;
        tick();
        bus1.rd_en = 1'b0;
        chk("re_vld",  bus1.rd_data_vld, 0);
        chk("re_err",  bus1.err, 2'b11);
        chk("re_hold", bus1.rd_data, 32'h55);

        // Latency-2 instance: back-to-back reads of 0..7
        for (int i = 0; i < 8; i++) begin
            bus2.wr_en   = 1'b1;
            bus2.wr_addr = 5'(i);
            bus2.wr_data = 32'hC0 + 32'(i);
            tick();
        end
        bus2.wr_en     = 1'b0;
        bus2.wr_commit = 1'b1;
        tick();
        bus2.wr_commit = 1'b0;
        chk("l2_frame", bus2.rd_frame_vld, 1);
        for (int k = 0; k < 10; k++) begin
            bus2.rd_en   = (k < 8);
            bus2.rd_addr = 5'(k);
            tick();
            chk("l2_vld", bus2.rd_data_vld, (k >= 1 && k <= 8) ? 1 : 0);
            if (k >= 1 && k <= 8) chk("l2_data", bus2.rd_data, 32'hC0 + 32'(k - 1));
        end
        bus2.rd_en = 1'b0;

        // Reset one cycle after a latency-2 read is issued
        bus2.rd_en   = 1'b1;
        bus2.rd_addr = 5'd2;
        tick();
        bus2.rd_en = 1'b0;
        rst = 1'b1;
        tick();
        chk("mr_vld",      bus2.rd_data_vld, 0);
        chk("mr_data",     bus2.rd_data, 0);
        chk("mr_wr_ready", bus2.wr_ready, 1);
        chk("mr_wr_bank",  bus2.wr_bank, 0);
        chk("mr_rd_bank",  bus2.rd_bank, 0);
        chk("mr_frame",    bus2.rd_frame_vld, 0);
        chk("mr_fill",     bus2.fill, 0);
        chk("mr_err",      bus2.err, 0);
        chk("mr_err1",     bus1.err, 0);
        chk("mr_wr_bank1", bus1.wr_bank, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mr_late_vld", bus2.rd_data_vld, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
